// File: rtl/alu_operand_serdes_pkg.sv
// Shared state encoding and helpers for the ALU operand/result serialiser.
package alu_operand_serdes_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // A 1-byte transfer ends at byte 0, a 2-byte transfer at byte 1.
  function automatic logic is_last_byte(input logic pair, input logic idx);
    return idx == pair;
  endfunction

endpackage

// File: rtl/alu_operand_serdes.sv
// Byte-stream <-> bit-serial bridge: loads a 1/2-byte operand, shifts it to the ALU
// NSHIFT bits per active cycle, captures the ALU result chunks and drains them as bytes.
module alu_operand_serdes
  import alu_operand_serdes_pkg::*;
#(
  parameter int unsigned REG_BITS = 8,
  parameter int unsigned NSHIFT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_pair,
  input  logic                cfg_load,
  input  logic                cfg_capture,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_BITS-1:0] in_data,
  output logic                req_op,
  input  logic                alu_active,
  input  logic                alu_op_done,
  output logic [NSHIFT-1:0]   alu_data_in,
  input  logic [NSHIFT-1:0]   alu_data_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_BITS-1:0] out_data,
  output logic                busy
);

  localparam int unsigned NCHUNK   = 2 * REG_BITS / NSHIFT;
  localparam int unsigned CNT_BITS = $clog2(NCHUNK);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(NCHUNK - 1);

  logic [1:0]            state_q, state_d;
  logic [2*REG_BITS-1:0] opnd_q, opnd_d;
  logic [2*REG_BITS-1:0] res_q, res_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  byte_idx_q, byte_idx_d;
  logic                  pair_q, pair_d;
  logic                  capture_q, capture_d;

  int unsigned chunk_lsb;
  int unsigned byte_lsb;

  assign chunk_lsb = 32'(cnt_q) * NSHIFT;
  assign byte_lsb  = 32'(byte_idx_q) * REG_BITS;

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    pair_d     = pair_q;
    capture_d  = capture_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          pair_d     = cfg_pair;
          capture_d  = cfg_capture;
          opnd_d     = '0;
          res_d      = '0;
          cnt_d      = '0;
          byte_idx_d = 1'b0;
          state_d    = cfg_load ? ST_LOAD : ST_RUN;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          opnd_d[byte_lsb +: REG_BITS] = in_data;
          if (is_last_byte(pair_q, byte_idx_q)) begin
            byte_idx_d = 1'b0;
            state_d    = ST_RUN;
          end else begin
            byte_idx_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (alu_active) begin
          res_d[chunk_lsb +: NSHIFT] = alu_data_out;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          // op_done only counts on a shifting cycle
          if (alu_op_done) begin
            cnt_d      = '0;
            byte_idx_d = 1'b0;
            state_d    = capture_q ? ST_DRAIN : ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (is_last_byte(pair_q, byte_idx_q)) begin
            byte_idx_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            byte_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      opnd_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      byte_idx_q <= 1'b0;
      pair_q     <= 1'b0;
      capture_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      pair_q     <= pair_d;
      capture_q  <= capture_d;
    end
  end

  assign cfg_ready   = (state_q == ST_IDLE);
  assign in_ready    = (state_q == ST_LOAD);
  assign req_op      = (state_q == ST_RUN);
  assign out_valid   = (state_q == ST_DRAIN);
  assign busy        = (state_q != ST_IDLE);
  assign alu_data_in = (state_q == ST_RUN) ? opnd_q[chunk_lsb +: NSHIFT] : '0;
  assign out_data    = (state_q == ST_DRAIN) ? res_q[byte_lsb +: REG_BITS] : '0;

endmodule

// File: tb/tb_alu_operand_serdes.sv
// Bench for alu_operand_serdes: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_operand_serdes;

  localparam int unsigned RB = 8;
  localparam int unsigned NS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready, cfg_pair, cfg_load, cfg_capture;
  logic          in_valid, in_ready;
  logic [RB-1:0] in_data;
  logic          req_op, alu_active, alu_op_done;
  logic [NS-1:0] alu_data_in, alu_data_out;
  logic          out_valid, out_ready;
  logic [RB-1:0] out_data;
  logic          busy;

  always #5 clk = ~clk;

  alu_operand_serdes #(.REG_BITS(RB), .NSHIFT(NS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_pair     (cfg_pair),
    .cfg_load     (cfg_load),
    .cfg_capture  (cfg_capture),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .req_op       (req_op),
    .alu_active   (alu_active),
    .alu_op_done  (alu_op_done),
    .alu_data_in  (alu_data_in),
    .alu_data_out (alu_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: operand/result held as plain integers, position tracked as counts.
  typedef enum int {MIdle, MLoad, MRun, MDrain} mphase_t;
  mphase_t     ph = MIdle;
  bit          mv = 1'b0;
  int unsigned m_opnd, m_res, m_k, m_got, m_out;
  bit          m_pair, m_cap;

  function automatic int unsigned nbytes();
    return m_pair ? 2 : 1;
  endfunction

  function automatic int unsigned chunk_pos();
    return 2 * ((m_k < 7) ? m_k : 7);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = MIdle; m_opnd = 0; m_res = 0; m_k = 0; m_got = 0; m_out = 0;
      mv = 1'b1;
    end else begin
      case (ph)
        MIdle: if (cfg_valid) begin
          m_pair = cfg_pair; m_cap = cfg_capture;
          m_opnd = 0; m_res = 0; m_k = 0; m_got = 0; m_out = 0;
          ph = cfg_load ? MLoad : MRun;
        end
        MLoad: if (in_valid) begin
          m_opnd = m_opnd | (32'(in_data) << (8 * m_got));
          m_got++;
          if (m_got == nbytes()) ph = MRun;
        end
        MRun: if (alu_active) begin
          m_res = (m_res & ~(32'h3 << chunk_pos())) | (32'(alu_data_out) << chunk_pos());
          m_k++;
          if (alu_op_done) begin
            m_k = 0;
            ph = m_cap ? MDrain : MIdle;
          end
        end
        MDrain: if (out_ready) begin
          m_out++;
          if (m_out == nbytes()) ph = MIdle;
        end
        default: ph = MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, ph == MIdle});
      chk("in_ready", {31'd0, in_ready}, {31'd0, ph == MLoad});
      chk("req_op", {31'd0, req_op}, {31'd0, ph == MRun});
      chk("out_valid", {31'd0, out_valid}, {31'd0, ph == MDrain});
      chk("busy", {31'd0, busy}, {31'd0, ph != MIdle});
      chk("alu_data_in", 32'(alu_data_in),
          (ph == MRun) ? ((m_opnd >> chunk_pos()) & 32'h3) : 32'd0);
      chk("out_data", 32'(out_data),
          (ph == MDrain) ? ((m_res >> (8 * m_out)) & 32'hFF) : 32'd0);
    end
  end

  // Observed traffic for the literal checks of the directed scenarios.
  logic [RB-1:0] outq[$];
  logic [NS-1:0] dinq[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) outq.push_back(out_data);
      if (req_op && alu_active) dinq.push_back(alu_data_in);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input bit p, input bit l, input bit c);
    cfg_valid = 1'b1; cfg_pair = p; cfg_load = l; cfg_capture = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic clear_obs();
    outq.delete();
    dinq.delete();
  endtask

  task automatic chk_outq(input string name, input int unsigned n, input logic [15:0] exp);
    chk({name, "_count"}, outq.size(), n);
    for (int i = 0; i < n && i < outq.size(); i++)
      chk(name, 32'(outq[i]), 32'(exp[8*i +: 8]));
  endtask

  int unsigned din_exp[4] = '{0, 1, 3, 2};
  int unsigned done_pct;

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_pair = 1'b0; cfg_load = 1'b0; cfg_capture = 1'b0;
    in_valid = 1'b0; in_data = '0; alu_active = 1'b0; alu_op_done = 1'b0;
    alu_data_out = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_data_in", 32'(alu_data_in), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // 8-bit loopback: 0xB4 shifts out as chunks 0,1,3,2 and returns intact.
    clear_obs();
    cfg(1'b0, 1'b1, 1'b1);
    chk("lb_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    in_valid = 1'b0;
    chk("lb_req_op", {31'd0, req_op}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      alu_active = 1'b1; alu_data_out = alu_data_in; alu_op_done = (i == 3);
      tick();
    end
    alu_active = 1'b0; alu_op_done = 1'b0;
    chk("lb_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lb_idle", {31'd0, cfg_ready}, 32'd1);
    chk("lb_din_count", dinq.size(), 32'd4);
    for (int i = 0; i < 4 && i < dinq.size(); i++) chk("lb_din", 32'(dinq[i]), din_exp[i]);
    chk_outq("lb_out", 1, 16'h00B4);

    // 16-bit with an all-ones result, then 5 stalled DRAIN cycles.
    clear_obs();
    cfg(1'b1, 1'b1, 1'b1);
    in_valid = 1'b1; in_data = 8'h34;
    tick();
    chk("w_in_ready_mid", {31'd0, in_ready}, 32'd1);
    in_data = 8'h12;
    tick();
    in_valid = 1'b0;
    chk("w_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      alu_active = 1'b1; alu_data_out = 2'd3; alu_op_done = (i == 7);
      tick();
    end
    alu_active = 1'b0; alu_op_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data", 32'(out_data), 32'hFF);
    end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    chk("bp_idle", {31'd0, cfg_ready}, 32'd1);
    chk_outq("w_out", 2, 16'hFFFF);

    // Early op_done after 3 active cycles leaves the upper chunks zero.
    clear_obs();
    cfg(1'b1, 1'b1, 1'b1);
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_active = 1'b1; alu_data_out = 2'd3; alu_op_done = (i == 2);
      tick();
    end
    alu_active = 1'b0; alu_op_done = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    chk_outq("early_out", 2, 16'h003F);

    // No load, no capture: zero operand, nothing returned.
    clear_obs();
    cfg(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      alu_active = 1'b1; alu_data_out = NS'($urandom_range(0, 3)); alu_op_done = (i == 7);
      tick();
    end
    alu_active = 1'b0; alu_op_done = 1'b0;
    chk("nl_idle_after_done", {31'd0, cfg_ready}, 32'd1);
    chk("nl_din_count", dinq.size(), 32'd8);
    for (int i = 0; i < 8 && i < dinq.size(); i++) chk("nl_din_zero", 32'(dinq[i]), 32'd0);
    tick();
    chk("nl_no_output", outq.size(), 32'd0);

    // Reset held two cycles in the middle of RUN aborts the transaction.
    cfg(1'b1, 1'b0, 1'b1);
    alu_active = 1'b1; alu_data_out = 2'd1;
    tick();
    alu_active = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("mr_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("mr_req_op", {31'd0, req_op}, 32'd0);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("mr_still_idle", {31'd0, busy}, 32'd0);

    // Randomized traffic; op_done density varies so the chunk counter saturates sometimes.
    for (int blk = 0; blk < 8; blk++) begin
      done_pct = (blk % 2 == 0) ? 4 : 25;
      for (int i = 0; i < 500; i++) begin
        rst_n        = ($urandom_range(0, 299) != 0);
        cfg_valid    = ($urandom_range(0, 99) < 30);
        cfg_pair     = 1'($urandom_range(0, 1));
        cfg_load     = 1'($urandom_range(0, 1));
        cfg_capture  = 1'($urandom_range(0, 1));
        in_valid     = ($urandom_range(0, 99) < 60);
        in_data      = RB'($urandom_range(0, 255));
        alu_active   = ($urandom_range(0, 99) < 60);
        alu_op_done  = ($urandom_range(0, 99) < done_pct);
        alu_data_out = NS'($urandom_range(0, 3));
        out_ready    = ($urandom_range(0, 99) < 60);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
